// File: rtl/sha1_pad_ctrl.sv
// SHA-1 front end: pads a byte stream (0x80, zeros, 64-bit length) and feeds 512-bit
// blocks to the core as 16 words. Define SHA1_PAD_LEN_CHK_EN for length saturation.
module sha1_pad_ctrl #(
  parameter int LENW = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        str_in,
  input  logic        lst_din,
  input  logic [7:0]  din,
  output logic        bsy,
  output logic        blk_vld,
  input  logic        blk_rdy,
  output logic [31:0] blk_word,
  output logic [3:0]  blk_idx,
  output logic        blk_last,
  input  logic        blk_done,
  output logic        msg_done,
  output logic        len_ovf
);
  typedef enum logic [2:0] {ACCEPT, PAD80, PADZ, PADLEN, FEED, WAIT} state_t;

  state_t            state_q, state_d;
  logic [15:0][31:0] blk_buf;
  logic [5:0]        ptr_q;
  logic [LENW-1:0]   bitlen_q;
  logic [3:0]        idx_q;
  logic              final_q, pend_pad_q, pad_phase_q, msg_done_q;
  logic              wr_en, drop;
  logic [7:0]        wr_byte;
  logic [63:0]       len64;

  assign len64 = 64'(bitlen_q);

`ifdef SHA1_PAD_LEN_CHK_EN
  localparam logic [LENW-1:0] LEN_MAX = {{(LENW-3){1'b1}}, 3'b000};
  logic ovf_q;
  // A byte that would push the count past its maximum is discarded.
  assign drop = (state_q == ACCEPT) && str_in && (bitlen_q == LEN_MAX);
  always_ff @(posedge clk) begin
    if (rst)       ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end
  assign len_ovf = ovf_q;
`else
  assign drop    = 1'b0;
  assign len_ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_byte = 8'h00;
    case (state_q)
      ACCEPT: begin
        wr_en   = str_in && !drop;
        wr_byte = din;
        if (wr_en && ptr_q == 6'd63) state_d = FEED;
        else if (lst_din)            state_d = PAD80;
      end
      PAD80: begin
        wr_en   = 1'b1;
        wr_byte = 8'h80;
        if (ptr_q == 6'd63)      state_d = FEED;
        else if (ptr_q == 6'd55) state_d = PADLEN;
        else                     state_d = PADZ;
      end
      PADZ: begin
        wr_en = 1'b1;
        if (ptr_q == 6'd63)      state_d = FEED;
        else if (ptr_q == 6'd55) state_d = PADLEN;
      end
      PADLEN: begin
        wr_en   = 1'b1;
        wr_byte = len64[{~ptr_q[2:0], 3'b000} +: 8];
        if (ptr_q == 6'd63) state_d = FEED;
      end
      FEED: if (blk_rdy && idx_q == 4'd15) state_d = WAIT;
      WAIT: begin
        if (blk_done) begin
          if (final_q)          state_d = ACCEPT;
          else if (pend_pad_q)  state_d = PAD80;
          else if (pad_phase_q) state_d = PADZ;
          else                  state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCEPT;
      ptr_q       <= 6'd0;
      bitlen_q    <= '0;
      idx_q       <= 4'd0;
      final_q     <= 1'b0;
      pend_pad_q  <= 1'b0;
      pad_phase_q <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_done_q <= 1'b0;
      if (wr_en) ptr_q <= ptr_q + 6'd1;
      case (state_q)
        ACCEPT: begin
          if (wr_en) bitlen_q <= bitlen_q + LENW'(8);
          if (wr_en && ptr_q == 6'd63) begin
            pend_pad_q  <= lst_din;
            pad_phase_q <= 1'b0;
          end
        end
        // A block filled during padding resumes zero-fill after the core is done.
        PAD80, PADZ: if (ptr_q == 6'd63) pad_phase_q <= 1'b1;
        PADLEN:      if (ptr_q == 6'd63) final_q <= 1'b1;
        FEED:        if (blk_rdy) idx_q <= idx_q + 4'd1;
        WAIT: begin
          if (blk_done) begin
            pend_pad_q <= 1'b0;
            if (final_q) begin
              msg_done_q <= 1'b1;
              final_q    <= 1'b0;
              bitlen_q   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) blk_buf[ptr_q[5:2]][{~ptr_q[1:0], 3'b000} +: 8] <= wr_byte;
  end

  assign bsy      = (state_q != ACCEPT);
  assign blk_vld  = (state_q == FEED);
  assign blk_word = blk_buf[idx_q];
  assign blk_idx  = idx_q;
  assign blk_last = final_q;
  assign msg_done = msg_done_q;
endmodule

// File: tb/tb_sha1_pad_ctrl.sv
// Bench for sha1_pad_ctrl: directed vector table plus random messages checked against a
// queue-based padding model; a core responder toggles blk_rdy and returns blk_done.
`timescale 1ns/1ps
module tb_sha1_pad_ctrl;
`ifdef SHA1_PAD_LEN_CHK_EN
  localparam int LW = 16;
`else
  localparam int LW = 64;
`endif

  logic        clk = 1'b0, rst = 1'b1, str_in = 1'b0, lst_din = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        bsy, blk_vld, blk_rdy, blk_last, blk_done, msg_done, len_ovf;
  logic [31:0] blk_word;
  logic [3:0]  blk_idx;

  always #5 clk = ~clk;

  sha1_pad_ctrl #(.LENW(LW)) dut (
    .clk(clk), .rst(rst), .str_in(str_in), .lst_din(lst_din), .din(din), .bsy(bsy),
    .blk_vld(blk_vld), .blk_rdy(blk_rdy), .blk_word(blk_word), .blk_idx(blk_idx),
    .blk_last(blk_last), .blk_done(blk_done), .msg_done(msg_done), .len_ovf(len_ovf)
  );

  typedef struct { logic [31:0] w; logic [3:0] idx; logic last; } xw_t;
  typedef struct { string nm; int n; int fill; int mode; int nblk;
                   logic [31:0] f0, f14, l0, l15; } vec_t;

  xw_t         exp_q[$];
  logic [31:0] cap_q[$];
  int n_cmp = 0, n_bad = 0, msgs_rcvd = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
  function automatic void model(input logic [7:0] m[$]);
    logic [7:0]    p[$];
    logic [LW-1:0] blw;
    logic [63:0]   bl;
    int            nb, o;
    xw_t           e;
    p   = m;
    blw = LW'(m.size() * 8);
    bl  = 64'(blw);
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++)
      for (int w = 0; w < 16; w++) begin
        o     = 64*b + 4*w;
        e.w   = {p[o], p[o+1], p[o+2], p[o+3]};
        e.idx = 4'(w);
        e.last = (b == nb - 1);
        exp_q.push_back(e);
      end
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (bsy) begin
      str_in = 1'($urandom); lst_din = 1'($urandom); din = 8'($urandom);
      @(negedge clk);
      if (++t > 3000) begin
        $display("FAIL bsy_timeout: bsy still 1 after %0d cycles, expected 0", t);
        $fatal(1);
      end
    end
  endtask

  // mode 0: lst_din with last byte, 1: lst_din on its own afterwards, 2: no lst_din
  task automatic send(input logic [7:0] m[$], input int mode);
    for (int i = 0; i < m.size(); i++) begin
      wait_idle();
      str_in = 1'b1; din = m[i]; lst_din = (mode == 0) && (i == m.size() - 1);
      @(negedge clk);
    end
    if (mode == 1) begin
      wait_idle();
      str_in = 1'b0; lst_din = 1'b1; din = 8'($urandom);
      @(negedge clk);
    end
    str_in = 1'b0; lst_din = 1'b0;
  endtask

  task automatic run_msg(input logic [7:0] m[$], input int mode, input int drop_n);
    logic [7:0] mm[$];
    int t = 0, target;
    mm = m;
    for (int i = 0; i < drop_n; i++) void'(mm.pop_back());
    cap_q.delete();
    model(mm);
    target = msgs_rcvd + 1;
    send(m, mode);
    while (msgs_rcvd < target) begin
      if (bsy) begin str_in = 1'($urandom); lst_din = 1'($urandom); din = 8'($urandom); end
      else     begin str_in = 1'b0; lst_din = 1'b0; end
      @(negedge clk);
      if (++t > 20000) begin
        $display("FAIL msg_timeout: msg_done not seen after %0d cycles", t);
        $fatal(1);
      end
    end
    str_in = 1'b0; lst_din = 1'b0;
    chk("words_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Core model: random blk_rdy, checks each word against the reference, pulses blk_done.
  initial begin : core
    int   dly = 0;
    bit   wt = 0, hold = 0, lastb = 0, md = 0;
    logic [31:0] hw;
    logic [3:0]  hi;
    logic        hl;
    xw_t  e;
    blk_rdy = 1'b0; blk_done = 1'b0;
    forever begin
      @(negedge clk);
      blk_done = 1'b0;
      if (rst) begin dly = 0; wt = 0; hold = 0; md = 0; blk_rdy = 1'b0; continue; end
      if (md || msg_done) begin
        chk("msg_done", 64'(msg_done), 64'(md));
        if (md) msgs_rcvd++;
        md = 0;
      end
      if (wt) begin
        chk("wait_vld", 64'(blk_vld), 64'd0);
        blk_rdy = 1'($urandom);
        if (dly == 0) begin blk_done = 1'b1; md = lastb; wt = 0; end
        else dly--;
      end else begin
        if (hold && blk_vld) begin
          chk("hold_word", 64'(blk_word), 64'(hw));
          chk("hold_idx", 64'(blk_idx), 64'(hi));
          chk("hold_last", 64'(blk_last), 64'(hl));
        end
        hold = 0;
        blk_rdy = ($urandom_range(0, 2) != 0);
        if (blk_vld) begin
          if (blk_rdy) begin
            if (exp_q.size() == 0) begin
              chk("extra_word", 64'(blk_idx), 64'hFFFF);
            end else begin
              e = exp_q.pop_front();
              chk("word", 64'(blk_word), 64'(e.w));
              chk("idx", 64'(blk_idx), 64'(e.idx));
              chk("last", 64'(blk_last), 64'(e.last));
              lastb = e.last;
            end
            cap_q.push_back(blk_word);
            if (blk_idx == 4'd15) begin wt = 1; dly = $urandom_range(0, 3); end
          end else begin
            hold = 1; hw = blk_word; hi = blk_idx; hl = blk_last;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          blk_done = 1'b1;  // outside WAIT this must be ignored
        end
      end
    end
  end

  initial begin : main
    vec_t       vt[8];
    logic [7:0] m[$];
    xw_t        e;
    int         t, n, mode;

    vt[0] = '{"empty", 0,  0,    1, 1, 32'h80000000, 32'h0, 32'h80000000, 32'h0};
    vt[1] = '{"abc",   3,  -1,   0, 1, 32'h61626380, 32'h0, 32'h61626380, 32'h18};
    vt[2] = '{"z56",   56, 0,    0, 2, 32'h0, 32'h80000000, 32'h0, 32'h1C0};
    vt[3] = '{"b64",   64, 'h11, 0, 2, 32'h11111111, 32'h11111111, 32'h80000000, 32'h200};
    vt[4] = '{"b55",   55, 'hAB, 0, 1, 32'hABABABAB, 32'h0, 32'hABABABAB, 32'h1B8};
    vt[5] = '{"b63",   63, 'h01, 0, 2, 32'h01010101, 32'h01010101, 32'h0, 32'h1F8};
    vt[6] = '{"b60s",  60, 'h22, 1, 2, 32'h22222222, 32'h22222222, 32'h0, 32'h1E0};
    vt[7] = '{"b120",  120,'h33, 0, 3, 32'h33333333, 32'h33333333, 32'h0, 32'h3C0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_bsy", 64'(bsy), 0);
    chk("rst_vld", 64'(blk_vld), 0);
    chk("rst_last", 64'(blk_last), 0);
    chk("rst_msg_done", 64'(msg_done), 0);
    chk("rst_len_ovf", 64'(len_ovf), 0);
    chk("rst_idx", 64'(blk_idx), 0);

    foreach (vt[k]) begin
      m.delete();
      for (int i = 0; i < vt[k].n; i++)
        m.push_back(vt[k].fill < 0 ? 8'(8'h61 + i) : 8'(vt[k].fill));
      run_msg(m, vt[k].mode, 0);
      chk({vt[k].nm, "_nblk"}, 64'(cap_q.size() / 16), 64'(vt[k].nblk));
      if (cap_q.size() >= 16) begin
        chk({vt[k].nm, "_first_w0"}, 64'(cap_q[0]), 64'(vt[k].f0));
        chk({vt[k].nm, "_first_w14"}, 64'(cap_q[14]), 64'(vt[k].f14));
        chk({vt[k].nm, "_last_w0"}, 64'(cap_q[cap_q.size() - 16]), 64'(vt[k].l0));
        chk({vt[k].nm, "_last_w15"}, 64'(cap_q[cap_q.size() - 1]), 64'(vt[k].l15));
      end
    end

    for (int r = 0; r < 12; r++) begin
      m.delete();
      n = $urandom_range(0, 140);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      mode = (n == 0) ? 1 : int'($urandom_range(0, 1));
      run_msg(m, mode, 0);
    end

    // Reset in the middle of a block transfer, then a clean "abc".
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    for (int w = 0; w < 16; w++) begin
      e.w = {m[4*w], m[4*w+1], m[4*w+2], m[4*w+3]}; e.idx = 4'(w); e.last = 1'b0;
      exp_q.push_back(e);
    end
    send(m, 2);
    t = 0;
    while (!(blk_vld && blk_idx >= 4'd4)) begin
      @(negedge clk);
      if (++t > 500) begin
        $display("FAIL feed_timeout: blk_idx did not reach 4 within %0d cycles", t);
        $fatal(1);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_vld", 64'(blk_vld), 0);
    chk("midrst_bsy", 64'(bsy), 0);
    chk("midrst_idx", 64'(blk_idx), 0);
    chk("midrst_last", 64'(blk_last), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m.delete();
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    run_msg(m, 0, 0);
    chk("post_rst_abc_w0", 64'(cap_q[0]), 64'h61626380);
    chk("post_rst_abc_w15", 64'(cap_q[15]), 64'h18);

`ifdef SHA1_PAD_LEN_CHK_EN
    chk("ovf_before", 64'(len_ovf), 0);
    m.delete();
    for (int i = 0; i < 8192; i++) m.push_back(8'($urandom));
    run_msg(m, 1, 1);
    chk("ovf_after", 64'(len_ovf), 1);
    chk("ovf_nblk", 64'(cap_q.size() / 16), 64'd129);
    chk("ovf_len_w15", 64'(cap_q[cap_q.size() - 1]), 64'h0000FFF8);
`else
    chk("len_ovf_tied", 64'(len_ovf), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
